// File: rtl/counter_cmd_sequencer.sv
// counter_cmd_sequencer: runs one {mode, data, len} command at a time from requesters A/B on a 4-bit counter.
// Latency: accept cycle, then len RUN cycles with cnt_enable=1, then a one-cycle DONE pulse (len+2 cycles total).
// Backpressure: req_x_ready is high only in IDLE and only for the round-robin winner; no command overlap.
//
// Ports:
//   clk, reset                  rising-edge clock, synchronous active-high reset
//   req_{a,b}_valid/ready       command handshake (ready is combinational)
//   req_{a,b}_mode/data/len     command payload: counter mode, load value, enabled-cycle count
//   cnt_rco                     ripple-carry-out returned by the counter
//   cnt_enable/cnt_mode/cnt_D   registered counter controls, zero outside RUN
//   busy                        high in RUN or DONE
//   done_valid/done_id/done_rco completion pulse, owner (0=A, 1=B), rco seen during the command
module counter_cmd_sequencer #(
  parameter int NBITS = 4,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_a_valid,
  input  logic [1:0]       req_a_mode,
  input  logic [NBITS-1:0] req_a_data,
  input  logic [LEN_W-1:0] req_a_len,
  output logic             req_a_ready,
  input  logic             req_b_valid,
  input  logic [1:0]       req_b_mode,
  input  logic [NBITS-1:0] req_b_data,
  input  logic [LEN_W-1:0] req_b_len,
  output logic             req_b_ready,
  input  logic             cnt_rco,
  output logic             cnt_enable,
  output logic [1:0]       cnt_mode,
  output logic [NBITS-1:0] cnt_D,
  output logic             busy,
  output logic             done_valid,
  output logic             done_id,
  output logic             done_rco
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_last_grant;   // 0=A, 1=B
  logic               r_owner;
  logic [1:0]         r_mode;
  logic [NBITS-1:0]   r_data;
  logic [LEN_W-1:0]   r_remaining;
  logic               r_rco_sticky;
  logic               r_cnt_enable;
  logic [1:0]         r_cnt_mode;
  logic [NBITS-1:0]   r_cnt_D;
  logic               r_done_valid;

  logic               w_idle;
  logic               w_grant_a;
  logic               w_grant_b;
  logic               w_accept;
  logic [1:0]         w_sel_mode;
  logic [NBITS-1:0]   w_sel_data;
  logic [LEN_W-1:0]   w_sel_len;
  logic [1:0]         w_mode_nxt;
  logic [NBITS-1:0]   w_data_nxt;

  // Round robin: a lone requester always wins; on a tie the one not granted last time wins.
  assign w_idle    = (r_state == S_IDLE);
  assign w_grant_a = req_a_valid && (!req_b_valid || r_last_grant);
  assign w_grant_b = req_b_valid && (!req_a_valid || !r_last_grant);

  assign req_a_ready = w_idle && w_grant_a;
  assign req_b_ready = w_idle && w_grant_b;
  assign w_accept    = req_a_ready || req_b_ready;

  assign w_sel_mode = w_grant_b ? req_b_mode : req_a_mode;
  assign w_sel_data = w_grant_b ? req_b_data : req_a_data;
  assign w_sel_len  = w_grant_b ? req_b_len  : req_a_len;

  // Counter controls are registered, so on the accept edge they must load the incoming payload.
  assign w_mode_nxt = w_accept ? w_sel_mode : r_mode;
  assign w_data_nxt = w_accept ? w_sel_data : r_data;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = (w_sel_len == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        // Leaving at 1 keeps remaining from ever wrapping below zero.
        if (r_remaining == LEN_W'(1)) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_mode       <= '0;
      r_data       <= '0;
      r_remaining  <= '0;
      r_rco_sticky <= 1'b0;
      r_cnt_enable <= 1'b0;
      r_cnt_mode   <= '0;
      r_cnt_D      <= '0;
      r_done_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;

      if (w_accept) begin
        r_mode       <= w_sel_mode;
        r_data       <= w_sel_data;
        r_remaining  <= w_sel_len;
        r_owner      <= w_grant_b;
        r_last_grant <= w_grant_b;
        r_rco_sticky <= 1'b0;
      end else if (r_state == S_RUN) begin
        r_remaining  <= r_remaining - LEN_W'(1);
        r_rco_sticky <= r_rco_sticky | cnt_rco;
      end

      r_cnt_enable <= (w_state_nxt == S_RUN);
      r_cnt_mode   <= (w_state_nxt == S_RUN) ? w_mode_nxt : 2'b00;
      r_cnt_D      <= (w_state_nxt == S_RUN) ? w_data_nxt : '0;
      r_done_valid <= (w_state_nxt == S_DONE);
    end
  end

  assign cnt_enable = r_cnt_enable;
  assign cnt_mode   = r_cnt_mode;
  assign cnt_D      = r_cnt_D;
  assign busy       = !w_idle;
  assign done_valid = r_done_valid;
  assign done_id    = r_done_valid && r_owner;
  // The counter's rco lags its enable by a cycle, so the live rco in DONE still belongs to this command.
  assign done_rco   = r_done_valid && (r_rco_sticky || cnt_rco);

endmodule

// File: tb/tb_counter_cmd_sequencer.sv
// tb_counter_cmd_sequencer: directed cycle table plus hand-written long-run sequences for counter_cmd_sequencer.
// Includes a 4-bit up/down/load counter so rco comes from real counting driven by the DUT.
// Expected outputs in the table are hand-computed per cycle.
module tb_counter_cmd_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_a_valid, req_b_valid;
  logic [1:0] req_a_mode, req_b_mode;
  logic [3:0] req_a_data, req_b_data;
  logic [3:0] req_a_len, req_b_len;
  logic       req_a_ready, req_b_ready;
  logic       cnt_rco;
  logic       cnt_enable;
  logic [1:0] cnt_mode;
  logic [3:0] cnt_D;
  logic       busy, done_valid, done_id, done_rco;
  logic [3:0] q;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  counter_cmd_sequencer #(.NBITS(4), .LEN_W(4)) dut (
    .clk(clk), .reset(reset),
    .req_a_valid(req_a_valid), .req_a_mode(req_a_mode), .req_a_data(req_a_data),
    .req_a_len(req_a_len), .req_a_ready(req_a_ready),
    .req_b_valid(req_b_valid), .req_b_mode(req_b_mode), .req_b_data(req_b_data),
    .req_b_len(req_b_len), .req_b_ready(req_b_ready),
    .cnt_rco(cnt_rco), .cnt_enable(cnt_enable), .cnt_mode(cnt_mode), .cnt_D(cnt_D),
    .busy(busy), .done_valid(done_valid), .done_id(done_id), .done_rco(done_rco)
  );

  // Counter: 00:+3, 01:-1, 10:+1, 11:load D; rco while Q is all ones.
  always_ff @(posedge clk) begin
    if (reset) q <= 4'd0;
    else if (cnt_enable) begin
      case (cnt_mode)
        2'b00:   q <= q + 4'd3;
        2'b01:   q <= q - 4'd1;
        2'b10:   q <= q + 4'd1;
        default: q <= cnt_D;
      endcase
    end
  end
  assign cnt_rco = (q == 4'hF);

  typedef struct {
    logic        rst;
    logic        av; logic [1:0] am; logic [3:0] ad; logic [3:0] al;
    logic        bv; logic [1:0] bm; logic [3:0] bd; logic [3:0] bl;
    logic [16:0] exp_out;  // {ar, br, en, mode, D, busy, dv, did, drco, q}
  } vec_t;

  vec_t vecs[$];

  task automatic v(input logic rst,
                   input logic av, input logic [1:0] am, input logic [3:0] ad, input logic [3:0] al,
                   input logic bv, input logic [1:0] bm, input logic [3:0] bd, input logic [3:0] bl,
                   input logic ar, input logic br, input logic en, input logic [1:0] m,
                   input logic [3:0] d, input logic bsy, input logic dv, input logic did,
                   input logic drco, input logic [3:0] eq);
    vec_t r;
    r.rst = rst;
    r.av = av; r.am = am; r.ad = ad; r.al = al;
    r.bv = bv; r.bm = bm; r.bd = bd; r.bl = bl;
    r.exp_out = {ar, br, en, m, d, bsy, dv, did, drco, eq};
    vecs.push_back(r);
  endtask

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
    end
  endtask

  // Issues one command, then follows it until the done pulse or a cycle budget runs out.
  task automatic run_cmd(input logic use_b, input logic [1:0] m, input logic [3:0] d,
                         input logic [3:0] l, output logic rdy, output int en_cycles,
                         output int wait_cycles, output logic dv_seen, output logic id);
    @(negedge clk);
    req_a_valid = !use_b; req_a_mode = m; req_a_data = d; req_a_len = l;
    req_b_valid = use_b;  req_b_mode = m; req_b_data = d; req_b_len = l;
    #1 rdy = use_b ? req_b_ready : req_a_ready;
    @(negedge clk);
    req_a_valid = 1'b0; req_b_valid = 1'b0;
    en_cycles = 0; wait_cycles = -1; dv_seen = 1'b0; id = 1'b0;
    for (int k = 0; k < 40 && !dv_seen; k++) begin
      #1;
      if (cnt_enable) en_cycles++;
      if (done_valid) begin
        dv_seen = 1'b1; id = done_id; wait_cycles = k;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  initial begin
    logic [16:0] act;
    logic rdy, dv_seen, id;
    int en_cycles, wait_cycles;

    // rst  A:v,m,d,l    B:v,m,d,l    ar,br,en,m,d,busy,dv,did,drco,q
    // A: load 5, len 1
    v(0, 0,0,0,0,  0,0,0,0,  0,0,0,0,0,0,0,0,0,0);
    v(0, 1,3,5,1,  0,0,0,0,  1,0,0,0,0,0,0,0,0,0);
    v(0, 0,0,0,0,  0,0,0,0,  0,0,1,3,5,1,0,0,0,0);
    v(0, 0,0,0,0,  0,0,0,0,  0,0,0,0,0,1,1,0,0,5);
    // A: +1, len 3 -> Q 8
    v(0, 1,2,0,3,  0,0,0,0,  1,0,0,0,0,0,0,0,0,5);
    v(0, 0,0,0,0,  0,0,0,0,  0,0,1,2,0,1,0,0,0,5);
    v(0, 0,0,0,0,  0,0,0,0,  0,0,1,2,0,1,0,0,0,6);
    v(0, 0,0,0,0,  0,0,0,0,  0,0,1,2,0,1,0,0,0,7);
    v(0, 0,0,0,0,  0,0,0,0,  0,0,0,0,0,1,1,0,0,8);
    // A: load 14
    v(0, 1,3,14,1, 0,0,0,0,  1,0,0,0,0,0,0,0,0,8);
    v(0, 0,0,0,0,  0,0,0,0,  0,0,1,3,14,1,0,0,0,8);
    v(0, 0,0,0,0,  0,0,0,0,  0,0,0,0,0,1,1,0,0,14);
    // B: +1, len 3 -> passes 15 and wraps, rco=1
    v(0, 0,0,0,0,  1,2,0,3,  0,1,0,0,0,0,0,0,0,14);
    v(0, 0,0,0,0,  0,0,0,0,  0,0,1,2,0,1,0,0,0,14);
    v(0, 0,0,0,0,  0,0,0,0,  0,0,1,2,0,1,0,0,0,15);
    v(0, 0,0,0,0,  0,0,0,0,  0,0,1,2,0,1,0,0,0,0);
    v(0, 0,0,0,0,  0,0,0,0,  0,0,0,0,0,1,1,1,1,1);
    // A: load 2, then +1 len 3 -> no rco
    v(0, 1,3,2,1,  0,0,0,0,  1,0,0,0,0,0,0,0,0,1);
    v(0, 0,0,0,0,  0,0,0,0,  0,0,1,3,2,1,0,0,0,1);
    v(0, 0,0,0,0,  0,0,0,0,  0,0,0,0,0,1,1,0,0,2);
    v(0, 1,2,0,3,  0,0,0,0,  1,0,0,0,0,0,0,0,0,2);
    v(0, 0,0,0,0,  0,0,0,0,  0,0,1,2,0,1,0,0,0,2);
    v(0, 0,0,0,0,  0,0,0,0,  0,0,1,2,0,1,0,0,0,3);
    v(0, 0,0,0,0,  0,0,0,0,  0,0,1,2,0,1,0,0,0,4);
    v(0, 0,0,0,0,  0,0,0,0,  0,0,0,0,0,1,1,0,0,5);
    // B: -1, len 6 -> reaches 15 only after last enable; rco seen live in DONE
    v(0, 0,0,0,0,  1,1,7,6,  0,1,0,0,0,0,0,0,0,5);
    v(0, 0,0,0,0,  0,0,0,0,  0,0,1,1,7,1,0,0,0,5);
    v(0, 0,0,0,0,  0,0,0,0,  0,0,1,1,7,1,0,0,0,4);
    v(0, 0,0,0,0,  0,0,0,0,  0,0,1,1,7,1,0,0,0,3);
    v(0, 0,0,0,0,  0,0,0,0,  0,0,1,1,7,1,0,0,0,2);
    v(0, 0,0,0,0,  0,0,0,0,  0,0,1,1,7,1,0,0,0,1);
    v(0, 0,0,0,0,  0,0,0,0,  0,0,1,1,7,1,0,0,0,0);
    v(0, 0,0,0,0,  0,0,0,0,  0,0,0,0,0,1,1,1,1,15);
    // B: len 0 -> straight to DONE, no enable; Q still 15 so rco reported
    v(0, 0,0,0,0,  1,0,0,0,  0,1,0,0,0,0,0,0,0,15);
    v(0, 0,0,0,0,  0,0,0,0,  0,0,0,0,0,1,1,1,1,15);
    // A: +3, len 1 from 15 -> 2
    v(0, 1,0,0,1,  0,0,0,0,  1,0,0,0,0,0,0,0,0,15);
    v(0, 0,0,0,0,  0,0,0,0,  0,0,1,0,0,1,0,0,0,15);
    v(0, 0,0,0,0,  0,0,0,0,  0,0,0,0,0,1,1,0,1,2);
    // A: +1 len 5, reset in 2nd RUN cycle
    v(0, 1,2,0,5,  0,0,0,0,  1,0,0,0,0,0,0,0,0,2);
    v(0, 0,0,0,0,  0,0,0,0,  0,0,1,2,0,1,0,0,0,2);
    v(1, 0,0,0,0,  0,0,0,0,  0,0,1,2,0,1,0,0,0,3);
    v(0, 0,0,0,0,  0,0,0,0,  0,0,0,0,0,0,0,0,0,0);
    v(0, 0,0,0,0,  0,0,0,0,  0,0,0,0,0,0,0,0,0,0);
    // Tie, both held valid: grant order A, B, A, B
    v(0, 1,2,3,2,  1,1,9,2,  1,0,0,0,0,0,0,0,0,0);
    v(0, 1,2,3,2,  1,1,9,2,  0,0,1,2,3,1,0,0,0,0);
    v(0, 1,2,3,2,  1,1,9,2,  0,0,1,2,3,1,0,0,0,1);
    v(0, 1,2,3,2,  1,1,9,2,  0,0,0,0,0,1,1,0,0,2);
    v(0, 1,2,3,2,  1,1,9,2,  0,1,0,0,0,0,0,0,0,2);
    v(0, 1,2,3,2,  1,1,9,2,  0,0,1,1,9,1,0,0,0,2);
    v(0, 1,2,3,2,  1,1,9,2,  0,0,1,1,9,1,0,0,0,1);
    v(0, 1,2,3,2,  1,1,9,2,  0,0,0,0,0,1,1,1,0,0);
    v(0, 1,2,3,2,  1,1,9,2,  1,0,0,0,0,0,0,0,0,0);
    v(0, 1,2,3,2,  1,1,9,2,  0,0,1,2,3,1,0,0,0,0);
    v(0, 1,2,3,2,  1,1,9,2,  0,0,1,2,3,1,0,0,0,1);
    v(0, 1,2,3,2,  1,1,9,2,  0,0,0,0,0,1,1,0,0,2);
    v(0, 1,2,3,2,  1,1,9,2,  0,1,0,0,0,0,0,0,0,2);
    v(0, 1,2,3,2,  1,1,9,2,  0,0,1,1,9,1,0,0,0,2);
    v(0, 1,2,3,2,  1,1,9,2,  0,0,1,1,9,1,0,0,0,1);
    v(0, 1,2,3,2,  1,1,9,2,  0,0,0,0,0,1,1,1,0,0);
    v(0, 0,0,0,0,  0,0,0,0,  0,0,0,0,0,0,0,0,0,0);

    reset = 1'b1;
    req_a_valid = 1'b0; req_a_mode = '0; req_a_data = '0; req_a_len = '0;
    req_b_valid = 1'b0; req_b_mode = '0; req_b_data = '0; req_b_len = '0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      reset       = vecs[i].rst;
      req_a_valid = vecs[i].av; req_a_mode = vecs[i].am;
      req_a_data  = vecs[i].ad; req_a_len  = vecs[i].al;
      req_b_valid = vecs[i].bv; req_b_mode = vecs[i].bm;
      req_b_data  = vecs[i].bd; req_b_len  = vecs[i].bl;
      #1;
      act = {req_a_ready, req_b_ready, cnt_enable, cnt_mode, cnt_D,
             busy, done_valid, done_id, done_rco, q};
      chk($sformatf("row%0d", i), int'(act), int'(vecs[i].exp_out));
    end

    // B alone, len 4: exactly 4 enabled cycles then done for B.
    run_cmd(1'b1, 2'b10, 4'd0, 4'd4, rdy, en_cycles, wait_cycles, dv_seen, id);
    chk("len4_ready", int'(rdy), 1);
    chk("len4_done_seen", int'(dv_seen), 1);
    chk("len4_enable_cycles", en_cycles, 4);
    chk("len4_done_id", int'(id), 1);
    chk("len4_done_delay", wait_cycles, 4);

    // A, maximum run length 15: no wrap of the remaining count.
    run_cmd(1'b0, 2'b10, 4'd0, 4'd15, rdy, en_cycles, wait_cycles, dv_seen, id);
    chk("len15_ready", int'(rdy), 1);
    chk("len15_done_seen", int'(dv_seen), 1);
    chk("len15_enable_cycles", en_cycles, 15);
    chk("len15_done_id", int'(id), 0);
    chk("len15_done_delay", wait_cycles, 15);
    @(negedge clk);
    #1;
    chk("idle_after_done_busy", int'(busy), 0);
    chk("idle_after_done_valid", int'(done_valid), 0);
    chk("counter_after_runs", int'(q), 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
